// File: rtl/pm_best_state_merge_if.sv
// Selector-to-merge and merge-to-traceback signal bundle.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
// valid/payload hold until that edge, ready may depend combinationally on the consumer.
interface pm_best_state_merge_if #(
    parameter int PM_W = 8,
    parameter int ST_W = 6
);
    logic            frame_start;
    logic            pm_valid;
    logic            pm_ready;
    logic            pm_slice;
    logic [ST_W-1:0] pm_index;
    logic [PM_W-1:0] pm_value;
    logic            best_valid;
    logic            best_ready;
    logic [ST_W-1:0] best_state;
    logic [PM_W-1:0] best_value;
    logic            tb_start;
    logic            seq_err;

    modport slave (
        input  frame_start, pm_valid, pm_slice, pm_index, pm_value, best_ready,
        output pm_ready, best_valid, best_state, best_value, tb_start, seq_err
    );

    modport master (
        output frame_start, pm_valid, pm_slice, pm_index, pm_value, best_ready,
        input  pm_ready, best_valid, best_state, best_value, tb_start, seq_err
    );
endinterface

// File: rtl/pm_best_state_merge.sv
// Merges the two half-trellis minimum-metric winners into one best state per step
// and flags every TB_DEPTH-th step as a traceback start.
module pm_best_state_merge #(
    parameter int PM_W     = 8,
    parameter int ST_W     = 6,
    parameter int TB_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pm_best_state_merge_if.slave        bus,
    output logic                        o_dbg_state,
    output logic [$clog2(TB_DEPTH)-1:0] o_dbg_step_cnt
);
    localparam int CW = $clog2(TB_DEPTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(TB_DEPTH - 1);

    typedef enum logic {
        S_WAIT0 = 1'b0,
        S_WAIT1 = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [ST_W-1:0] r_cand_idx;
    logic [PM_W-1:0] r_cand_val;
    logic [CW-1:0]   r_step_cnt;
    logic            r_best_valid;
    logic [ST_W-1:0] r_best_state;
    logic [PM_W-1:0] r_best_value;
    logic            r_tb_start;
    logic            r_seq_err;

    logic            w_pm_ready;
    logic            w_accept;
    logic            w_cap;
    logic            w_merge;
    logic            w_seq_err;
    logic            w_cand_lt;
    logic [ST_W-1:0] w_merge_idx;
    logic [PM_W-1:0] w_merge_val;

    // Only a slice-1 merge can collide with an unconsumed result, so stall just that case.
    assign w_pm_ready = ~((r_state == S_WAIT1) & r_best_valid & ~bus.best_ready);
    assign w_accept   = bus.pm_valid & w_pm_ready;

    // Wrap-aware compare: metrics live on a circle, MSB acts as the lap bit.
    assign w_cand_lt   = r_cand_val[PM_W-1] ^ bus.pm_value[PM_W-1] ^
                         (r_cand_val[PM_W-2:0] < bus.pm_value[PM_W-2:0]);
    assign w_merge_idx = w_cand_lt ? r_cand_idx : bus.pm_index;
    assign w_merge_val = w_cand_lt ? r_cand_val : bus.pm_value;

    always_comb begin
        w_next    = r_state;
        w_cap     = 1'b0;
        w_merge   = 1'b0;
        w_seq_err = 1'b0;
        if (bus.frame_start) begin
            w_next = S_WAIT0;
        end else if (w_accept) begin
            unique case (r_state)
                S_WAIT0: begin
                    if (!bus.pm_slice) begin
                        w_cap  = 1'b1;
                        w_next = S_WAIT1;
                    end else begin
                        w_seq_err = 1'b1;
                    end
                end
                S_WAIT1: begin
                    if (bus.pm_slice) begin
                        w_merge = 1'b1;
                        w_next  = S_WAIT0;
                    end else begin
                        w_cap     = 1'b1;
                        w_seq_err = 1'b1;
                    end
                end
                default: w_next = S_WAIT0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT0;
            r_cand_idx <= '0;
            r_cand_val <= '0;
            r_step_cnt <= '0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_seq_err <= w_seq_err;
            if (w_cap) begin
                r_cand_idx <= bus.pm_index;
                r_cand_val <= bus.pm_value;
            end
            if (bus.frame_start) begin
                r_step_cnt <= '0;
            end else if (w_merge) begin
                r_step_cnt <= (r_step_cnt == LAST_STEP) ? '0 : r_step_cnt + CW'(1);
            end
        end
    end

    // State/value are left as-is when the result is consumed or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_valid <= 1'b0;
            r_best_state <= '0;
            r_best_value <= '0;
            r_tb_start   <= 1'b0;
        end else if (bus.frame_start) begin
            r_best_valid <= 1'b0;
            r_tb_start   <= 1'b0;
        end else if (w_merge) begin
            r_best_valid <= 1'b1;
            r_best_state <= w_merge_idx;
            r_best_value <= w_merge_val;
            r_tb_start   <= (r_step_cnt == LAST_STEP);
        end else if (r_best_valid && bus.best_ready) begin
            r_best_valid <= 1'b0;
            r_tb_start   <= 1'b0;
        end
    end

    assign bus.pm_ready    = w_pm_ready;
    assign bus.best_valid  = r_best_valid;
    assign bus.best_state  = r_best_state;
    assign bus.best_value  = r_best_value;
    assign bus.tb_start    = r_tb_start;
    assign bus.seq_err     = r_seq_err;
    assign o_dbg_state     = r_state;
    assign o_dbg_step_cnt  = r_step_cnt;
endmodule
